// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Contents: FSM state encoding, word width, address field positions and
// the default geometry (10-bit byte address, 8 lines, 128-bit lines).
package icache_pkg;

  localparam int WORD_W  = 32;
  // Byte address layout: [1:0] byte (ignored), [3:2] word offset,
  // [IDX_LSB +: IDX_W] line index, remaining upper bits are the tag.
  localparam int OFF_LSB = 2;
  localparam int OFF_W   = 2;
  localparam int IDX_LSB = OFF_LSB + OFF_W;

  localparam int ICACHE_ADDR_W    = 10;
  localparam int ICACHE_NUM_LINES = 8;
  localparam int ICACHE_IDX_W     = $clog2(ICACHE_NUM_LINES);
  localparam int ICACHE_TAG_LSB   = IDX_LSB + ICACHE_IDX_W;
  localparam int ICACHE_TAG_W     = ICACHE_ADDR_W - ICACHE_TAG_LSB;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

endpackage

// File: rtl/icache_word_select.sv
// Combinational 4:1 word mux: picks 32-bit word `offset` out of a cache line.
// Ports: line (LINE_W block, word k at [32k+31:32k]), offset (word index),
//        word (selected instruction).
module icache_word_select
  import icache_pkg::*;
#(
  parameter int LINE_W = 128
) (
  input  logic [LINE_W-1:0] line,
  input  logic [OFF_W-1:0]  offset,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = line[{offset, 5'd0} +: WORD_W];
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between CPU fetch and a
// 128-bit-block instruction memory with a read/busywait handshake.
// Ports:
//   clock, reset_n          - clock, async active-low reset
//   cpu_read, address       - fetch request (level) and byte address (PC)
//   instruction, busywait   - fetched word, CPU stall
//   mem_read, mem_address   - block read request and block address
//   mem_readinst            - returned block
//   mem_busywait            - memory busy
// Optional feature (macro ICACHE_STATS_EN): hit_count / miss_count outputs,
// 16-bit saturating counters.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES = ICACHE_NUM_LINES,
  parameter int ADDR_W    = ICACHE_ADDR_W,
  parameter int LINE_W    = 128
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cpu_read,
  input  logic [ADDR_W-1:0]   address,
  output logic [WORD_W-1:0]   instruction,
  output logic                busywait,
  output logic                mem_read,
  output logic [ADDR_W-5:0]   mem_address,
  input  logic [LINE_W-1:0]   mem_readinst,
`ifdef ICACHE_STATS_EN
  input  logic                mem_busywait,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
`else
  input  logic                mem_busywait
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int BLK_W = ADDR_W - IDX_LSB;
  localparam int TAG_W = BLK_W - IDX_W;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [LINE_W-1:0]    data [NUM_LINES];

  state_t state, state_nxt;
  logic   first;   // first cycle of MEM_READ: memory has not yet answered

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              miss;
  logic [WORD_W-1:0] word;
  logic              addr_unused;

  assign addr_unused = ^address[OFF_LSB-1:0];

  assign idx  = address[IDX_LSB +: IDX_W];
  assign tag  = address[ADDR_W-1 -: TAG_W];
  assign hit  = valid[idx] && (tags[idx] == tag);
  assign miss = (state == IDLE) && cpu_read && !hit;

  // Fill location comes from the registered block address, not the live PC.
  assign fill_idx = mem_address[IDX_W-1:0];
  assign fill_tag = mem_address[BLK_W-1 -: TAG_W];

  icache_word_select #(.LINE_W(LINE_W)) u_word_select (
    .line   (data[idx]),
    .offset (address[OFF_LSB +: OFF_W]),
    .word   (word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (miss) state_nxt = MEM_READ;
      MEM_READ: if (!first && !mem_busywait) state_nxt = UPDATE;
      UPDATE:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = (state == MEM_READ);
    instruction = hit ? word : '0;
    // Gated by reset so the stall drops immediately while reset is held.
    busywait    = reset_n && ((state != IDLE) || (cpu_read && !hit));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      first       <= 1'b0;
      valid       <= '0;
      mem_address <= '0;
    end else begin
      state <= state_nxt;
      first <= miss;
      if (miss) mem_address <= address[ADDR_W-1:IDX_LSB];
      if (state == UPDATE) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; valid bits guard them.
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= mem_readinst;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && cpu_read && hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (miss && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a behavioural
// block memory that raises mem_busywait for mem_delay cycles per request.
module tb_instruction_cache;

  logic         clock;
  logic         reset_n;
  logic         cpu_read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readinst;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int errors = 0;
  int checks = 0;
  int mem_delay = 2;

  instruction_cache dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cpu_read     (cpu_read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readinst (mem_readinst),
`ifdef ICACHE_STATS_EN
    .mem_busywait (mem_busywait),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`else
    .mem_busywait (mem_busywait)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Block 0 and 1 are hand-written; others: word k = {16'hA000 + blk, k}.
  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] b;
    case (a)
      6'h00: b = {32'h1100_0100, 32'h1000_0001, 32'h0001_0001, 32'h0000_0009};
      6'h01: b = {32'h0E03_0003, 32'h0E03_0002, 32'h0E03_0001, 32'h0E03_0000};
      default: begin
        for (int k = 0; k < 4; k++) b[32*k +: 32] = {16'hA000 + {10'd0, a}, 16'(k)};
      end
    endcase
    return b;
  endfunction

  // Memory model: sees mem_read at a negedge, stays busy mem_delay cycles.
  initial begin
    int  cnt;
    bit  served;
    cnt = 0; served = 0;
    mem_busywait = 1'b0;
    mem_readinst = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        mem_busywait = 1'b0; served = 0; cnt = 0;
      end else if (mem_busywait) begin
        cnt--;
        if (cnt <= 0) begin
          mem_readinst = blk(mem_address);
          mem_busywait = 1'b0;
          served = 1;
        end
      end else if (mem_read && !served) begin
        mem_busywait = 1'b1;
        cnt = mem_delay;
      end else if (!mem_read) begin
        served = 0;
      end
    end
  end

  // Issue one fetch starting at a negedge. A miss returns at the negedge
  // where busywait has fallen (no extra posedge); a hit consumes one posedge.
  task automatic fetch(input string nm, input logic [9:0] a, input logic [31:0] exp,
                       input bit miss, input logic [5:0] exp_ma);
    int n;
    address = a; cpu_read = 1'b1;
    #1;
    checks++;
    if (busywait !== miss) begin
      errors++; $display("FAIL %s busywait got %b exp %b", nm, busywait, miss);
    end
    if (miss) begin
      @(negedge clock);
      checks++;
      if (mem_read !== 1'b1) begin
        errors++; $display("FAIL %s mem_read got %b exp 1", nm, mem_read);
      end
      checks++;
      if (mem_address !== exp_ma) begin
        errors++; $display("FAIL %s mem_address got %h exp %h", nm, mem_address, exp_ma);
      end
      n = 1;
      while (busywait === 1'b1 && n < 200) begin
        @(negedge clock); n++;
      end
      checks++;
      if (n != 3 + mem_delay) begin
        errors++; $display("FAIL %s miss_cycles got %0d exp %0d", nm, n, 3 + mem_delay);
      end
    end else begin
      checks++;
      if (mem_read !== 1'b0) begin
        errors++; $display("FAIL %s mem_read got %b exp 0", nm, mem_read);
      end
    end
    checks++;
    if (instruction !== exp) begin
      errors++; $display("FAIL %s instruction got %h exp %h", nm, instruction, exp);
    end
    checks++;
    if (busywait !== 1'b0) begin
      errors++; $display("FAIL %s busywait_done got %b exp 0", nm, busywait);
    end
    if (!miss) @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== 32'h0) begin
      errors++;
      $display("FAIL %s bw/mr/instr got %b/%b/%h exp 0/0/0", nm, busywait, mem_read, instruction);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cpu_read = 1'b0; address = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_read = 1'b0; address = '0;
    #2;
    check_idle_outputs("reset_held");
    checks++;
    if (mem_address !== 6'h00) begin
      errors++; $display("FAIL reset mem_address got %h exp 00", mem_address);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check_idle_outputs("reset_released");
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      errors++; $display("FAIL reset_counters got %h/%h exp 0/0", hit_count, miss_count);
    end
`endif
    @(negedge clock);
  endtask

  task automatic test_first_miss();
    mem_delay = 40;
    fetch("miss_000", 10'h000, 32'h0000_0009, 1'b1, 6'h00);
    mem_delay = 2;
  endtask

  task automatic test_hits();
    fetch("hit_004", 10'h004, 32'h0001_0001, 1'b0, 6'h00);
    fetch("hit_008", 10'h008, 32'h1000_0001, 1'b0, 6'h00);
    fetch("hit_00C", 10'h00C, 32'h1100_0100, 1'b0, 6'h00);
    fetch("hit_003", 10'h003, 32'h0000_0009, 1'b0, 6'h00);
  endtask

  task automatic test_second_line();
    fetch("miss_010", 10'h010, 32'h0E03_0000, 1'b1, 6'h01);
    fetch("hit_014",  10'h014, 32'h0E03_0001, 1'b0, 6'h00);
    fetch("hit_008b", 10'h008, 32'h1000_0001, 1'b0, 6'h00);
  endtask

  task automatic test_conflict();
    fetch("hit_000",   10'h000, 32'h0000_0009, 1'b0, 6'h00);
    fetch("miss_080",  10'h080, 32'hA008_0000, 1'b1, 6'h08);
    fetch("hit_08C",   10'h08C, 32'hA008_0003, 1'b0, 6'h00);
    fetch("evict_000", 10'h000, 32'h0000_0009, 1'b1, 6'h00);
    fetch("hit_014b",  10'h014, 32'h0E03_0001, 1'b0, 6'h00);
  endtask

  task automatic test_reset_mid_miss();
    address = 10'h080; cpu_read = 1'b1;
    @(negedge clock);
    checks++;
    if (mem_read !== 1'b1) begin
      errors++; $display("FAIL pre_reset mem_read got %b exp 1", mem_read);
    end
    #1 reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_miss");
    @(negedge clock);
    reset_n = 1'b1;
    cpu_read = 1'b0;
    #1;
    check_idle_outputs("after_release");
    @(negedge clock);
    fetch("refetch_000", 10'h000, 32'h0000_0009, 1'b1, 6'h00);
    fetch("refetch_010", 10'h010, 32'h0E03_0000, 1'b1, 6'h01);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    fetch("st_000", 10'h000, 32'h0000_0009, 1'b1, 6'h00);
    fetch("st_004", 10'h004, 32'h0001_0001, 1'b0, 6'h00);
    fetch("st_008", 10'h008, 32'h1000_0001, 1'b0, 6'h00);
    fetch("st_080", 10'h080, 32'hA008_0000, 1'b1, 6'h08);
    fetch("st_000b", 10'h000, 32'h0000_0009, 1'b1, 6'h00);
    cpu_read = 1'b0;
    @(negedge clock);
    checks++;
    if (hit_count !== 16'd2) begin
      errors++; $display("FAIL stats hit_count got %0d exp 2", hit_count);
    end
    checks++;
    if (miss_count !== 16'd3) begin
      errors++; $display("FAIL stats miss_count got %0d exp 3", miss_count);
    end
    do_reset();
    fetch("sat_000", 10'h000, 32'h0000_0009, 1'b1, 6'h00);
    repeat (65534) @(negedge clock);
    checks++;
    if (hit_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre hit_count got %h exp FFFE", hit_count);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (hit_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat hit_count got %h exp FFFF", hit_count);
    end
    checks++;
    if (miss_count !== 16'd1) begin
      errors++; $display("FAIL sat miss_count got %0d exp 1", miss_count);
    end
    cpu_read = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0; cpu_read = 1'b0; address = '0;
    @(negedge clock);
    test_reset();
    test_first_miss();
    test_hits();
    test_second_line();
    test_conflict();
    test_reset_mid_miss();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
